// File: rtl/mult_pkg.sv
// Shared types and default sizing for the carry-save MAC back-end.
// The state enum is used by the accumulator FSM.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/csa_split_adder.sv
// Two-stage split adder that resolves one carry-save row pair into an IN_W+1-bit sum.
// Stage 1 registers the low-half sum and carry; stage 2 finishes the high half.
module csa_split_adder
    import mult_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] a,
    input  logic [IN_W-1:0] b,
    output logic [IN_W:0]   sum,
    output logic            s1_valid,
    output logic            s2_valid
);

    localparam int LO_W = IN_W / 2;
    localparam int HI_W = IN_W - LO_W;

    logic [LO_W-1:0] lo_reg;
    logic            c1_reg;
    logic [HI_W-1:0] a_hi_reg;
    logic [HI_W-1:0] b_hi_reg;
    logic            v1_reg;
    logic            v2_reg;
    logic [HI_W:0]   hi_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else begin
            v1_reg <= in_valid;
            v2_reg <= v1_reg;
        end
    end

    // Data registers only move on a valid pair; no reset needed on the datapath.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            {c1_reg, lo_reg} <= {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};
            a_hi_reg         <= a[IN_W-1:LO_W];
            b_hi_reg         <= b[IN_W-1:LO_W];
        end
    end

    always_comb begin
        hi_sum = {1'b0, a_hi_reg} + {1'b0, b_hi_reg} + {{HI_W{1'b0}}, c1_reg};
        sum    = {hi_sum, lo_reg};
    end

    // The second stage's result is consumed by the accumulator on the edge after
    // stage 1, so the finished sum is valid while stage 1 holds data.
    assign s1_valid = v1_reg;
    assign s2_valid = v2_reg;

endmodule

// File: rtl/mult_csa_accumulator.sv
// MAC back-end: accumulates resolved carry-save row pairs over a programmed job
// length and hands the total out over a valid/ready handshake.
module mult_csa_accumulator
    import mult_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_row_a,
    input  logic [IN_W-1:0]  in_row_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] remaining_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;

    logic             accept;
    logic             start_ok;
    logic [IN_W:0]    row_sum;
    logic             s1_valid;
    logic             s2_valid;
    logic [ACC_W:0]   acc_sum;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state_reg == IDLE);

    csa_split_adder #(
        .IN_W(IN_W)
    ) u_adder (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .a        (in_row_a),
        .b        (in_row_b),
        .sum      (row_sum),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (remaining_reg == CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == RUN) && (remaining_reg != '0);
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    // Zero-extend the IN_W+1-bit row sum; the extra MSB catches the carry-out.
    assign acc_sum = {1'b0, acc_reg} + {{(ACC_W - IN_W){1'b0}}, row_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_reg <= '0;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else if (start_ok) begin
            remaining_reg <= len;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            if (accept) begin
                remaining_reg <= remaining_reg - CNT_W'(1);
            end
            if (s1_valid) begin
                acc_reg <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign out_acc = acc_reg;
    assign out_ovf = ovf_reg;

endmodule

// File: tb/tb_mult_csa_accumulator.sv
// Randomized self-checking bench for mult_csa_accumulator against a plain-arithmetic job model.
module tb_mult_csa_accumulator;

    localparam int IN_W  = 16;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam longint ACC_MOD = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_row_a;
    logic [IN_W-1:0]  in_row_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic             busy;

    int errors = 0;
    int checks = 0;

    // Job model: running total modulo 2^ACC_W plus sticky carry-out flag.
    longint exp_acc  = 0;
    bit     exp_ovf  = 1'b0;
    int     job_len  = 0;
    int     accepted = 0;

    mult_csa_accumulator #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row_a  (in_row_a),
        .in_row_b  (in_row_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_add(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        longint t;
        t = exp_acc + longint'(a) + longint'(b);
        if (t >= ACC_MOD) exp_ovf = 1'b1;
        exp_acc = t % ACC_MOD;
    endfunction

    // Compare process: outputs against the model, then fold in this cycle's accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready && accepted >= job_len)
                chk("in_ready_beyond_len", in_ready, 0);
            if (out_valid) begin
                chk("out_acc", longint'(out_acc), exp_acc);
                chk("out_ovf", longint'(out_ovf), longint'(exp_ovf));
            end
            if (in_valid && in_ready) begin
                model_add(in_row_a, in_row_b);
                accepted++;
            end
        end
    end

    task automatic run_job(input int n, input bit rnd, input logic [IN_W-1:0] fa,
                           input logic [IN_W-1:0] fb, input int pct, input int hold,
                           input bit poke, input bit use_lit, input logic [ACC_W-1:0] lit_acc,
                           input bit lit_ovf, input int exp_lat);
        int sent;
        int cyc;
        int lat;
        bit acc;
        exp_acc  = 0;
        exp_ovf  = 1'b0;
        accepted = 0;
        job_len  = n;
        len      = CNT_W'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        len      = CNT_W'($urandom);
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 4000) begin
            if (!in_valid && $urandom_range(99) < pct) begin
                in_valid = 1'b1;
                in_row_a = rnd ? IN_W'($urandom) : fa;
                in_row_b = rnd ? IN_W'($urandom) : fb;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (sent < n) chk("accept_timeout", sent, n);
        if (pct == 100 && n > 0) chk("no_bubbles_cycles", cyc, n);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_timeout", out_valid, 1);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        if (use_lit) begin
            chk("lit_acc", longint'(out_acc), longint'(lit_acc));
            chk("lit_ovf", longint'(out_ovf), longint'(lit_ovf));
        end
        for (int i = 0; i < hold; i++) begin
            if (poke && i == hold / 2) begin
                start = 1'b1;
                len   = CNT_W'(3);
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        start     = poke;
        len       = CNT_W'(5);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("acc_kept_idle", longint'(out_acc), exp_acc);
        chk("ovf_kept_idle", longint'(out_ovf), longint'(exp_ovf));
        $display("job len=%0d acc=%0h ovf=%0d latency=%0d", n, out_acc, out_ovf, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent;
        bit acc;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_row_a  = '0;
        in_row_b  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", longint'(out_acc), 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(1,   1'b0, 16'h0003, 16'h0004, 100, 0,  1'b0, 1'b1, 24'h000007, 1'b0, 3);
        run_job(4,   1'b0, 16'hFE01, 16'h0000, 100, 0,  1'b0, 1'b1, 24'h03F804, 1'b0, -1);
        run_job(255, 1'b0, 16'hFFFF, 16'hFFFF, 100, 0,  1'b0, 1'b1, 24'hFDFE02, 1'b1, -1);
        run_job(0,   1'b0, 16'h0000, 16'h0000, 100, 0,  1'b0, 1'b1, 24'h000000, 1'b0, 0);
        for (int j = 0; j < 4; j++)
            run_job($urandom_range(1, 30), 1'b1, 16'h0, 16'h0, 50, 10, 1'b1, 1'b0, 24'h0, 1'b0, -1);
        run_job(255, 1'b1, 16'h0, 16'h0, 70, 3, 1'b1, 1'b0, 24'h0, 1'b0, -1);

        // Abort a job after two accepts; the partial sum must vanish.
        exp_acc  = 0;
        exp_ovf  = 1'b0;
        accepted = 0;
        job_len  = 5;
        len      = CNT_W'(5);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sent  = 0;
        for (int k = 0; k < 20 && sent < 2; k++) begin
            in_valid = 1'b1;
            in_row_a = IN_W'($urandom);
            in_row_b = IN_W'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("abort_accepts", sent, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        accepted = 0;
        job_len  = 0;
        exp_acc  = 0;
        exp_ovf  = 1'b0;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_acc", longint'(out_acc), 0);
        chk("abort_out_ovf", out_ovf, 0);
        chk("abort_busy", busy, 0);
        $display("abort after %0d accepts acc=%0h", sent, out_acc);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_output", out_valid, 0);
        end
        run_job(1, 1'b0, 16'h0001, 16'h0001, 100, 2, 1'b0, 1'b1, 24'h000002, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
